// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters (CPU = m0, DMA = m1), the
// arbiter, and the shared memory/IO port.
interface mem_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic [31:0] m1_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requester / memory-model side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master fair arbiter onto a single-cycle shared memory port.
// One access every three cycles: IDLE (arbitrate) -> ACCESS -> CAPTURE.
module mem_bus_arbiter (
  input  logic              clock,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state_reg;
  logic        last_grant_reg;
  logic        owner_reg;
  logic        we_reg;
  logic        mem_en_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [1:0]  gnt_reg;
  logic [1:0]  done_reg;
  logic        busy_reg;

  logic [1:0]  req_vec;
  logic        winner_next;
  logic        we_next;
  logic [31:0] addr_next;
  logic [31:0] wdata_next;

  assign req_vec = {bus.m1_req, bus.m0_req};

  // Lone requester wins; on contention the master not granted last wins.
  always_comb begin
    winner_next = ~last_grant_reg;
    case (req_vec)
      2'b01:   winner_next = 1'b0;
      2'b10:   winner_next = 1'b1;
      default: winner_next = ~last_grant_reg;
    endcase
  end

  assign we_next    = winner_next ? bus.m1_we    : bus.m0_we;
  assign addr_next  = winner_next ? bus.m1_addr  : bus.m0_addr;
  assign wdata_next = winner_next ? bus.m1_wdata : bus.m0_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      we_reg         <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      gnt_reg        <= '0;
      done_reg       <= '0;
      busy_reg       <= 1'b0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            state_reg      <= ACCESS;
            owner_reg      <= winner_next;
            last_grant_reg <= winner_next;
            we_reg         <= we_next;
            mem_en_reg     <= 1'b1;
            mem_we_reg     <= we_next;
            mem_addr_reg   <= addr_next;
            mem_wdata_reg  <= wdata_next;
            gnt_reg        <= winner_next ? 2'b10 : 2'b01;
            busy_reg       <= 1'b1;
          end
        end
        ACCESS: begin
          state_reg  <= CAPTURE;
          mem_en_reg <= 1'b0;
          mem_we_reg <= 1'b0;
        end
        CAPTURE: begin
          // done lands in the following IDLE cycle, where a new grant may also start.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= owner_reg ? 2'b10 : 2'b01;
        end
        default: begin
          state_reg  <= IDLE;
          mem_en_reg <= 1'b0;
          mem_we_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  // Per-master read-data holding registers; writes leave them untouched.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdata
      logic [31:0] rdata_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if (state_reg == CAPTURE && !we_reg && owner_reg == 1'(gi)) begin
          rdata_reg <= bus.mem_rdata;
        end
      end
    end
  endgenerate

  assign bus.m0_gnt    = gnt_reg[0];
  assign bus.m1_gnt    = gnt_reg[1];
  assign bus.m0_done   = done_reg[0];
  assign bus.m1_done   = done_reg[1];
  assign bus.m0_rdata  = g_rdata[0].rdata_reg;
  assign bus.m1_rdata  = g_rdata[1].rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have no parameters; all address and data widths are fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_req, m1_req  input  1 each  access request from master 0 (CPU) / master 1 (DMA); held until granted.
REQ-005 m0_we, m1_we  input  1 each  1 = write, 0 = read; qualified by req.
REQ-006 m0_addr, m1_addr  input  32 each  byte address; qualified by req.
REQ-007 m0_wdata, m1_wdata  input  32 each  write data; qualified by req.
REQ-008 m0_gnt, m1_gnt  output  1 each  one-cycle pulse: request accepted, master may release req.
REQ-009 m0_done, m1_done  output  1 each  one-cycle pulse: access complete, rdata valid.
REQ-010 m0_rdata, m1_rdata  output  32 each  read data, valid during done, held until that master's next done.
REQ-011 mem_en, mem_we  output  1 each  shared memory/IO port strobe and write enable.
REQ-012 mem_addr, mem_wdata  output  32 each  shared port address and write data.
REQ-013 mem_rdata  input  32  shared port read data, valid one cycle after the mem_en cycle.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS and CAPTURE; all outputs SHALL be registered.
REQ-016 IDLE: if no req is high, the FSM SHALL stay in IDLE; otherwise it SHALL select a winner, latch the winner's we/addr/wdata and owner, and go to ACCESS.
REQ-017 Single requester: that requester SHALL win.
REQ-018 Both requesters: the master not granted last SHALL win; last_grant SHALL update on every grant.
REQ-019 ACCESS (exactly one cycle): the block SHALL drive mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values and owner gnt=1, then go to CAPTURE.
REQ-020 CAPTURE (exactly one cycle): the block SHALL drive mem_en=0 and mem_we=0, register mem_rdata into the owner's rdata, then go to IDLE.
REQ-021 The owner's done SHALL pulse for one cycle in the IDLE cycle following CAPTURE, for both reads and writes.
REQ-022 For writes, rdata SHALL be left unchanged.
REQ-023 Latency SHALL be: req sampled in IDLE at cycle T, gnt and mem_en at T+1, mem_rdata sampled at T+2, done and rdata at T+3.
REQ-024 A new arbitration MAY occur in the same IDLE cycle as done; peak throughput SHALL be one access per 3 cycles.
REQ-025 req SHALL be sampled only in IDLE; changes to req/we/addr/wdata during ACCESS or CAPTURE SHALL be ignored.
REQ-026 A master SHALL deassert req by the cycle after its gnt; req still high in a later IDLE SHALL be treated as a new request.
REQ-027 At most one gnt and at most one done SHALL be high in any cycle.
REQ-028 mem_we SHALL never be high while mem_en is low.
REQ-029 mem_addr/mem_wdata SHALL be passed unmodified; IO vs RAM decode (addr[7]) is the downstream block's responsibility.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE, last_grant=1 (so m0 wins first contention), and mem_en, mem_we, gnt, done and busy all 0.
REQ-031 On reset, mem_addr, mem_wdata, m0_rdata and m1_rdata SHALL be 0x00000000.
REQ-032 Reset during ACCESS or CAPTURE SHALL abort the transaction: no done pulse, no rdata update, mem_en and mem_we low from the next cycle.

Verification
REQ-033 m0 reads 0x4, mem_rdata=0xDEADBEEF at T+2 -> m0_gnt at T+1, mem_en=1/mem_we=0/mem_addr=0x4 at T+1, m0_done with m0_rdata=0xDEADBEEF at T+3.
REQ-034 m1 writes 0x12345678 to 0x80 -> mem_we=1, mem_addr=0x80, mem_wdata=0x12345678 for exactly one cycle; m1_done at T+3; m1_rdata unchanged.
REQ-035 m0 and m1 assert req together after reset and hold until gnt -> grants in order m0, m1, m0 on repeated contention; each grant 3 cycles apart.
REQ-036 Reset asserted during ACCESS of an m1 write -> no m1_done; mem_we=0 next cycle; the next contention is granted to m0.
REQ-037 m0 changes addr/wdata during CAPTURE -> mem_addr/mem_wdata and m0_rdata reflect the originally latched request.
REQ-038 Random traffic with an invariant monitor -> no cycle with two gnts or two dones; mem_we implies mem_en; every gnt is followed by exactly one done 2 cycles later.
